// File: rtl/serial_digit_adder.sv
// serial_digit_adder: a + b + cin computed one DIGIT-bit slice per cycle.
// A small carry chain is reused over WIDTH/DIGIT cycles, and the carry
// between slices is held in a register. Valid/ready handshakes are used
// on both sides. Every output is a flop, so no input reaches an output
// through combinational logic.

module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    // Reject parameter sets where the digits do not tile the operand exactly
    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_digit_adder: DIGIT must divide WIDTH with 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    count;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] psum_next;

    // One DIGIT-bit slice: the low digits of both operands plus the running carry
    always_comb begin
        digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    end

    // New digits enter at the MSB end, so after NCYC shifts the first digit sits at bit 0
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign psum_next = digit_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign psum_next = {digit_sum[DIGIT-1:0], psum[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Handshake FSM and datapath. The sum/cout registers load only when the last digit completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            carry     <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        psum     <= '0;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    psum  <= psum_next;
                    carry <= digit_sum[DIGIT];
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        sum       <= psum_next;
                        cout      <= digit_sum[DIGIT];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Testbench for serial_digit_adder. Three instances cover W8/D1, W16/D4
// and W8/D2. A whole-number model predicts each instance's handshake
// outputs and result on every cycle, and directed scenarios add literal
// expectations for key results.

module tb_serial_digit_adder;

    localparam int NRAND = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv  = 3'b000;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b1;

    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  co;
    logic [2:0]  bz;
    logic [7:0]  s0;
    logic [15:0] s1;
    logic [7:0]  s2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[0]),
        .out_ready(out_ready), .sum(s0), .cout(co[0]), .busy(bz[0])
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[1]),
        .out_ready(out_ready), .sum(s1), .cout(co[1]), .busy(bz[1])
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[2]),
        .out_ready(out_ready), .sum(s2), .cout(co[2]), .busy(bz[2])
    );

    function automatic logic [15:0] dutSum(input int k);
        case (k)
            0:       return {8'h00, s0};
            1:       return s1;
            default: return {8'h00, s2};
        endcase
    endfunction

    // Reference model: width and cycle count per instance; the result is whole-number arithmetic
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    int          wid[3]  = '{8, 16, 8};
    int          ncyc[3] = '{8, 4, 4};
    mstate_t     ms[3];
    int          rem[3];
    logic [31:0] res[3];
    logic [15:0] exp_sum[3];
    logic        exp_cout[3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance the reference model on each rising edge using the inputs presented to the DUTs
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [31:0] mask;
            mask = (32'h1 << wid[k]) - 32'h1;
            if (rst) begin
                ms[k]       = M_IDLE;
                rem[k]      = 0;
                exp_sum[k]  = '0;
                exp_cout[k] = 1'b0;
            end else begin
                case (ms[k])
                    M_IDLE: if (iv[k]) begin
                        res[k] = ({16'h0, a} & mask) + ({16'h0, b} & mask) + {31'h0, cin};
                        rem[k] = ncyc[k];
                        ms[k]  = M_RUN;
                    end
                    M_RUN: begin
                        rem[k]--;
                        if (rem[k] == 0) begin
                            ms[k]       = M_DONE;
                            exp_sum[k]  = res[k][15:0] & mask[15:0];
                            exp_cout[k] = res[k][wid[k]];
                        end
                    end
                    default: if (out_ready) ms[k] = M_IDLE;
                endcase
            end
        end
        if (!rst && iv[2] && ir[2]) acc_cnt++;
    end

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("inst%0d_in_ready", k), {31'h0, ir[k]}, {31'h0, ms[k] == M_IDLE});
                checkOutput($sformatf("inst%0d_out_valid", k), {31'h0, ov[k]}, {31'h0, ms[k] == M_DONE});
                checkOutput($sformatf("inst%0d_busy", k), {31'h0, bz[k]}, {31'h0, ms[k] != M_IDLE});
                checkOutput($sformatf("inst%0d_sum", k), {16'h0, dutSum(k)}, {16'h0, exp_sum[k]});
                checkOutput($sformatf("inst%0d_cout", k), {31'h0, co[k]}, {31'h0, exp_cout[k]});
            end
        end
    end

    // Present one operand set for a single cycle on instance k; it is taken at the following edge
    task automatic applyStimulus(input int k, input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(posedge clk); #1;
        a = av; b = bv; cin = cv; iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    // Wait for out_valid on instance k; lat is the cycle number counted from acceptance cycle 0
    task automatic waitResult(input int k, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ov[k]) seen = 1'b1;
            else lat++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL inst%0d_result_timeout: got no out_valid, expected one within 50 cycles", k);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        checkOutput("reset_in_ready", {31'h0, ir[0]}, 32'h1);
        checkOutput("reset_out_valid", {31'h0, ov[0]}, 32'h0);
        checkOutput("reset_sum", {24'h0, s0}, 32'h0);
        checkOutput("reset_busy", {31'h0, bz[0]}, 32'h0);

        $display("[TB] scenario 1: carry ripple through all eight bits");
        applyStimulus(0, 16'h00FF, 16'h0001, 1'b0);
        waitResult(0, lat);
        checkOutput("t1_latency", lat, 32'd9);
        checkOutput("t1_sum", {24'h0, s0}, 32'h00);
        checkOutput("t1_cout", {31'h0, co[0]}, 32'h1);

        $display("[TB] scenario 2: back-to-back operations");
        applyStimulus(0, 16'h005A, 16'h00A5, 1'b1);
        waitResult(0, lat);
        checkOutput("t2a_sum", {24'h0, s0}, 32'h00);
        checkOutput("t2a_cout", {31'h0, co[0]}, 32'h1);
        applyStimulus(0, 16'h0012, 16'h0034, 1'b0);
        waitResult(0, lat);
        checkOutput("t2b_sum", {24'h0, s0}, 32'h46);
        checkOutput("t2b_cout", {31'h0, co[0]}, 32'h0);

        $display("[TB] scenario 3: output backpressure");
        out_ready = 1'b0;
        applyStimulus(0, 16'h0012, 16'h0034, 1'b0);
        waitResult(0, lat);
        @(posedge clk); #1;
        iv[0] = 1'b1; a = 16'h00AA; b = 16'h0077; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_hold_valid", {31'h0, ov[0]}, 32'h1);
            checkOutput("t3_hold_in_ready", {31'h0, ir[0]}, 32'h0);
            checkOutput("t3_hold_sum", {24'h0, s0}, 32'h46);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t3_released_valid", {31'h0, ov[0]}, 32'h0);
        checkOutput("t3_kept_sum", {24'h0, s0}, 32'h46);
        checkOutput("t3_not_taken_busy", {31'h0, bz[0]}, 32'h0);

        $display("[TB] scenario 4: reset during RUN");
        applyStimulus(0, 16'h0033, 16'h0044, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_out_valid", {31'h0, ov[0]}, 32'h0);
        checkOutput("t4_sum", {24'h0, s0}, 32'h0);
        checkOutput("t4_cout", {31'h0, co[0]}, 32'h0);
        checkOutput("t4_in_ready", {31'h0, ir[0]}, 32'h1);
        applyStimulus(0, 16'h000F, 16'h0001, 1'b0);
        waitResult(0, lat);
        checkOutput("t4_after_sum", {24'h0, s0}, 32'h10);

        $display("[TB] scenario 5: 16-bit, 4-bit digits, all ones");
        applyStimulus(1, 16'hFFFF, 16'hFFFF, 1'b1);
        waitResult(1, lat);
        checkOutput("t5_latency", lat, 32'd5);
        checkOutput("t5_sum", {16'h0, s1}, 32'hFFFF);
        checkOutput("t5_cout", {31'h0, co[1]}, 32'h1);

        $display("[TB] scenario 6: random stream on 8-bit, 2-bit digits");
        @(posedge clk); #1;
        acc_cnt = 0;
        iv[2] = 1'b1;
        for (int i = 0; i < 6 * NRAND; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
        end
        iv[2] = 1'b0;
        checkOutput("t6_accept_count", acc_cnt, NRAND);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
